// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
//   Bundle between the RV32I pipeline datapath and the hazard scoreboard.
//   Signal names keep the scoreboard's point of view (i_* into it, o_* out).
//
//   Modports:
//     master : pipeline/datapath side, drives the i_* stage information,
//              receives the stall/flush/forwarding controls.
//     slave  : the hazard_scoreboard itself.
//
//   Parameters:
//     REG_AW          register index width
//     MAX_OUTSTANDING maximum loads in flight (sizes o_ld_pending)
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int REG_AW          = 5,
  parameter int MAX_OUTSTANDING = 2
);
  localparam int PEND_W = $clog2(MAX_OUTSTANDING + 1);

  // Decode stage
  logic [REG_AW-1:0] i_rs1_d;
  logic [REG_AW-1:0] i_rs2_d;
  logic [REG_AW-1:0] i_rd_d;
  logic              i_is_load_d;
  // Execute stage
  logic [REG_AW-1:0] i_rs1_e;
  logic [REG_AW-1:0] i_rs2_e;
  logic [REG_AW-1:0] i_rd_e;
  logic              i_rd_wren_e;
  logic              i_is_load_e;
  // Memory / writeback stages
  logic [REG_AW-1:0] i_rd_m;
  logic              i_rd_wren_m;
  logic [REG_AW-1:0] i_rd_wb;
  logic              i_rd_wren_wb;
  // Control flow and load responses
  logic              i_br_taken;
  logic              i_ld_rsp_valid;
  logic [REG_AW-1:0] i_ld_rsp_rd;
  // Controls back to the datapath
  logic [1:0]        o_fwd_a_sel;
  logic [1:0]        o_fwd_b_sel;
  logic              o_stall_f;
  logic              o_stall_d;
  logic              o_flush_d;
  logic              o_flush_e;
  logic [PEND_W-1:0] o_ld_pending;
  logic [1:0]        o_err;
  logic [31:0]       o_stall_cycles;
  logic [31:0]       o_flush_cycles;

  modport master (
    output i_rs1_d, i_rs2_d, i_rd_d, i_is_load_d,
    output i_rs1_e, i_rs2_e, i_rd_e, i_rd_wren_e, i_is_load_e,
    output i_rd_m, i_rd_wren_m, i_rd_wb, i_rd_wren_wb,
    output i_br_taken, i_ld_rsp_valid, i_ld_rsp_rd,
    input  o_fwd_a_sel, o_fwd_b_sel, o_stall_f, o_stall_d,
    input  o_flush_d, o_flush_e, o_ld_pending, o_err,
    input  o_stall_cycles, o_flush_cycles
  );

  modport slave (
    input  i_rs1_d, i_rs2_d, i_rd_d, i_is_load_d,
    input  i_rs1_e, i_rs2_e, i_rd_e, i_rd_wren_e, i_is_load_e,
    input  i_rd_m, i_rd_wren_m, i_rd_wb, i_rd_wren_wb,
    input  i_br_taken, i_ld_rsp_valid, i_ld_rsp_rd,
    output o_fwd_a_sel, o_fwd_b_sel, o_stall_f, o_stall_d,
    output o_flush_d, o_flush_e, o_ld_pending, o_err,
    output o_stall_cycles, o_flush_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard control for a 5-stage RV32I pipeline whose data memory answers
//   loads with a tagged, variable-latency response.
//   - Tracks a per-register "load in flight" bit and the number of loads in
//     flight.
//   - Stalls D on load-use, load WAW and outstanding-limit hazards; a taken
//     branch/jump in E flushes D and E and overrides any stall.
//   - Selects E-stage operand forwarding (M over WB over register file).
//   - Flags a response timeout and responses for registers not in flight
//     (sticky until reset).
//
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      hazard_scoreboard_if.slave (stage info in, controls out)
//
//   Optional build macro:
//     HAZ_PERF_CNT_EN  builds the stall/flush cycle counters; without it
//                      o_stall_cycles / o_flush_cycles are constant 0.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int REG_AW          = 5,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT         = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  hazard_scoreboard_if.slave    bus
);

  localparam int PEND_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMO_W  = $clog2(TIMEOUT);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_WB = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // State
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [1:0]          err_q, err_d;

  // Decoded events
  logic issue;
  logic rsp_hit;
  logic lu, waw, full, hz;

  // Register compare that never matches x0.
  function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Busy lookup that tolerates indices beyond NUM_REGS. busy_q[0] is never
  // set, so x0 always reads as not busy.
  function automatic logic is_busy(input logic [NUM_REGS-1:0] vec,
                                   input logic [REG_AW-1:0]   idx);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (idx == REG_AW'(r)) hit = vec[r];
    end
    return hit;
  endfunction

  function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] rs);
    if (bus.i_rd_wren_m && reg_match(bus.i_rd_m, rs))        return FWD_M;
    else if (bus.i_rd_wren_wb && reg_match(bus.i_rd_wb, rs)) return FWD_WB;
    else                                                     return FWD_RF;
  endfunction

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  assign issue   = bus.i_is_load_e && bus.i_rd_wren_e && (bus.i_rd_e != '0);
  assign rsp_hit = bus.i_ld_rsp_valid && is_busy(busy_q, bus.i_ld_rsp_rd);

  assign lu   = is_busy(busy_q, bus.i_rs1_d) || is_busy(busy_q, bus.i_rs2_d) ||
                (bus.i_is_load_e && (reg_match(bus.i_rd_e, bus.i_rs1_d) ||
                                     reg_match(bus.i_rd_e, bus.i_rs2_d)));
  assign waw  = bus.i_is_load_d && (is_busy(busy_q, bus.i_rd_d) ||
                (bus.i_is_load_e && reg_match(bus.i_rd_e, bus.i_rd_d)));
  // The load in E counts as already in flight: it issues on this edge.
  assign full = bus.i_is_load_d &&
                ((int'(pend_q) + int'(issue)) == MAX_OUTSTANDING);
  assign hz   = lu || waw || full;

  // A taken branch discards both younger instructions, so it overrides any
  // stall: holding F/D would only preserve an instruction being squashed.
  assign bus.o_stall_f = hz && !bus.i_br_taken;
  assign bus.o_stall_d = hz && !bus.i_br_taken;
  assign bus.o_flush_d = bus.i_br_taken;
  assign bus.o_flush_e = bus.i_br_taken || hz;

  assign bus.o_fwd_a_sel = fwd_sel(bus.i_rs1_e);
  assign bus.o_fwd_b_sel = fwd_sel(bus.i_rs2_e);

  assign bus.o_ld_pending = pend_q;
  assign bus.o_err        = err_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned here gets its default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    tmo_d  = tmo_q;
    err_d  = err_q;

    // The WAW stall guarantees issue and response never name the same
    // register, so the set and clear below cannot collide.
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue && (bus.i_rd_e == REG_AW'(r)))          busy_d[r] = 1'b1;
      if (rsp_hit && (bus.i_ld_rsp_rd == REG_AW'(r)))   busy_d[r] = 1'b0;
    end

    // A spurious response does not decrement, so pending cannot underflow.
    unique case ({issue, rsp_hit})
      2'b10:   pend_d = pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase

    // Timeout watches for silence from memory while anything is in flight;
    // the counter saturates since the error bit is sticky anyway.
    if (bus.i_ld_rsp_valid || (pend_q == '0)) begin
      tmo_d = '0;
    end else begin
      if (tmo_q == TMO_LAST) err_d[0] = 1'b1;
      else                   tmo_d    = tmo_q + TMO_W'(1);
    end

    if (bus.i_ld_rsp_valid && !rsp_hit) err_d[1] = 1'b1;
  end

  // NOTE: the busy bitmap is ordinary flops (not a RAM), so it is reset
  // along with everything else; an async reset must drop all in-flight loads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= '0;
      pend_q <= '0;
      tmo_q  <= '0;
      err_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // the pre-edge value regardless of statement order.
      busy_q <= busy_d;
      pend_q <= pend_d;
      tmo_q  <= tmo_d;
      err_q  <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.o_stall_d)  stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.i_br_taken) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.o_stall_cycles = stall_cnt_q;
  assign bus.o_flush_cycles = flush_cnt_q;
`else
  assign bus.o_stall_cycles = '0;
  assign bus.o_flush_cycles = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard control for the 5-stage RV32I pipeline, with variable-latency data memory (loads complete via a tagged response, not at fixed M/WB timing).
- Keeps a per-register pending-load scoreboard, resolves load-use, WAW and outstanding-limit stalls in D, and generates E-stage forwarding selects.
- Applies branch/jump flushes and flags memory-response protocol errors.
- Sits beside the datapath. Drives stall/flush enables of the F/D and D/E pipeline registers and the E-stage operand muxes.

Parameters:
- NUM_REGS, 32, architectural register count; x0 is never tracked.
- REG_AW, 5, register index width; must satisfy 2**REG_AW >= NUM_REGS.
- MAX_OUTSTANDING, 2, maximum loads in flight (1..8).
- TIMEOUT, 64, cycles without any response while loads are pending before the timeout error; >= 2.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_rs1_d, i_rs2_d  in  REG_AW  source registers of instruction in D
- i_rd_d  in  REG_AW  destination of instruction in D
- i_is_load_d  in  1  instruction in D is a load
- i_rs1_e, i_rs2_e  in  REG_AW  source registers of instruction in E
- i_rd_e  in  REG_AW  destination of instruction in E
- i_rd_wren_e  in  1  E writes rd
- i_is_load_e  in  1  E is a load
- i_rd_m  in  REG_AW  destination in M
- i_rd_wren_m  in  1  M writes rd and M is not a load
- i_rd_wb  in  REG_AW  destination in WB
- i_rd_wren_wb  in  1  WB writes rd
- i_br_taken  in  1  branch taken or JAL/JALR resolved in E
- i_ld_rsp_valid  in  1  memory load response this cycle; the register file is written in this same cycle
- i_ld_rsp_rd  in  REG_AW  destination tag of response
- o_fwd_a_sel, o_fwd_b_sel  out  2  00 = RF, 01 = WB, 10 = M
- o_stall_f, o_stall_d  out  1  hold PC / F-D register
- o_flush_d, o_flush_e  out  1  bubble into F-D / D-E register
- o_ld_pending  out  $clog2(MAX_OUTSTANDING+1)  loads in flight
- o_err  out  2  sticky: [0] timeout, [1] spurious response
- o_stall_cycles, o_flush_cycles  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - busy[] = 0, o_ld_pending = 0, timeout counter = 0, o_err = 0, perf counters = 0.
  - The combinational outputs then evaluate to 0.
- Load issue: issue = i_is_load_e & i_rd_wren_e & (i_rd_e != 0).
  - On a clock edge with issue: busy[i_rd_e] <= 1 and pending + 1.
- Response: on an edge with i_ld_rsp_valid:
  - If busy[i_ld_rsp_rd] is set: clear it and pending − 1.
  - Otherwise: set o_err[1]; busy and pending are unchanged.
- Issue and response in the same cycle: pending is unchanged net. They always target different registers, guaranteed by the WAW stall.
- Hazard conditions (combinational, rs/rd of 0 never match):
  - lu = (rs1_d or rs2_d is busy) or (i_is_load_e & rd_e matches rs1_d/rs2_d).
  - waw = i_is_load_d & (busy[rd_d] or (i_is_load_e & rd_e == rd_d)).
  - full = i_is_load_d & (pending + issue == MAX_OUTSTANDING).
  - hz = lu | waw | full.
- A response clears busy only at the edge. A stall on that register therefore releases one cycle after i_ld_rsp_valid, and D then reads the written RF value. No response forwarding.
- Stall and flush outputs:
  - hz & ~i_br_taken: o_stall_f = o_stall_d = o_flush_e = 1.
  - i_br_taken: o_flush_d = o_flush_e = 1 and o_stall_f = o_stall_d = 0. Flush wins over a simultaneous hz.
- Forwarding, per operand:
  - 10 if i_rd_wren_m & rd_m != 0 & rd_m == rs_e.
  - Else 01 if i_rd_wren_wb & rd_wb != 0 & rd_wb == rs_e.
  - Else 00.
  - M has priority over WB.
- Timeout counter:
  - Cleared on any response or when pending == 0; otherwise increments.
  - On reaching TIMEOUT − 1, the next edge sets o_err[0].
  - o_err bits hold until reset.
- Pending never exceeds MAX_OUTSTANDING and never underflows: a spurious response does not decrement.
- Reset asserted mid-operation discards all in-flight tracking immediately.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - o_stall_cycles increments on each cycle with o_stall_d = 1.
  - o_flush_cycles increments on each cycle with i_br_taken = 1.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports are tied to 0, and no counter flops are built.

Test Plan:
- Load x5 in E, then add using x5 in D the next cycle:
  - The add stalls (stall_f/stall_d/flush_e = 1) until the cycle after i_ld_rsp_valid with tag 5.
  - o_ld_pending goes 0 → 1 → 0.
- rd_m = rd_wb = 7, both enabled, rs1_e = 7 -> o_fwd_a_sel = 10.
  - Same case with M disabled -> 01.
  - rs1_e = 0 -> 00.
- MAX_OUTSTANDING = 2, two loads (x1, x2) pending, a third load (x3) in D:
  - full stall is held.
  - A response for x1 releases it the next cycle.
  - A load x2 in D is held by waw until the x2 response.
- hz and i_br_taken in the same cycle -> flush_d = flush_e = 1, stall_f = stall_d = 0.
- One load pending and no response for 64 cycles -> o_err[0] = 1 on cycle 64 and stays set. A response with tag 9 when x9 is not busy -> o_err[1] = 1 and pending is unchanged.
- With HAZ_PERF_CNT_EN: 3 stall cycles and 2 branch flushes -> o_stall_cycles = 3, o_flush_cycles = 2. Asserting i_rst_n = 0 mid-test clears the counters, busy and pending asynchronously.
